// File: rtl/mips_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mips_bus_arbiter_if
//  Purpose  : Bundle of the two requester ports (instruction fetch m0, data
//             m1), the shared memory port (s_*) and the sticky watchdog flag.
//             The slave modport is the arbiter's view; master is the view of
//             the requesters plus memory surrounding it.
//  Revision : 1.0  initial release
// ============================================================================
interface mips_bus_arbiter_if;
    // Requester 0: instruction fetch
    logic [31:0] m0_address;
    logic        m0_read;
    logic        m0_write;
    logic [31:0] m0_writedata;
    logic [3:0]  m0_byteenable;
    logic        m0_waitrequest;
    logic [31:0] m0_readdata;
    // Requester 1: data load/store
    logic [31:0] m1_address;
    logic        m1_read;
    logic        m1_write;
    logic [31:0] m1_writedata;
    logic [3:0]  m1_byteenable;
    logic        m1_waitrequest;
    logic [31:0] m1_readdata;
    // Shared memory port
    logic [31:0] s_address;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic [3:0]  s_byteenable;
    logic        s_waitrequest;
    logic [31:0] s_readdata;
    // Sticky watchdog flag
    logic        timeout_err;

    modport slave (
        input  m0_address, m0_read, m0_write, m0_writedata, m0_byteenable,
        output m0_waitrequest, m0_readdata,
        input  m1_address, m1_read, m1_write, m1_writedata, m1_byteenable,
        output m1_waitrequest, m1_readdata,
        output s_address, s_read, s_write, s_writedata, s_byteenable,
        input  s_waitrequest, s_readdata,
        output timeout_err
    );

    modport master (
        output m0_address, m0_read, m0_write, m0_writedata, m0_byteenable,
        input  m0_waitrequest, m0_readdata,
        output m1_address, m1_read, m1_write, m1_writedata, m1_byteenable,
        input  m1_waitrequest, m1_readdata,
        input  s_address, s_read, s_write, s_writedata, s_byteenable,
        output s_waitrequest, s_readdata,
        input  timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/mips_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mips_bus_arbiter
//  Purpose  : Two-master round-robin arbiter in front of the single memory
//             port of mips_cpu_bus. A grant is held until the memory drops
//             waitrequest; a per-grant watchdog aborts stalled accesses.
//  Revision : 1.0  initial release
// ============================================================================
module mips_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64,  // 0 disables the watchdog
    parameter int unsigned CNT_W          = 8    // TIMEOUT_CYCLES < 2**CNT_W
) (
    input  wire logic          clk,
    input  wire logic          reset,
    mips_bus_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

    state_t             state_q, state_d;
    logic               lg_q, lg_d;           // last master that completed
    logic [CNT_W-1:0]   cnt_q, cnt_d;         // stalled cycles in this grant
    logic               timeout_err_q;

    logic req0, req1, gnt0, gnt1, granted, abort, done;

    assign req0    = bus.m0_read | bus.m0_write;
    assign req1    = bus.m1_read | bus.m1_write;
    assign gnt0    = (state_q == GNT0);
    assign gnt1    = (state_q == GNT1);
    assign granted = gnt0 | gnt1;

    // Watchdog fires on the stalled cycle after TIMEOUT_CYCLES stalls
    assign abort = (TIMEOUT_CYCLES != 0) && granted && bus.s_waitrequest && (cnt_q == TMO);
    assign done  = granted & (~bus.s_waitrequest | abort);

    // Next-state: arbitration, grant hand-over and watchdog counting
    always_comb begin
        state_d = state_q;
        lg_d    = lg_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Tie goes to the master that did not complete last
                if (req0 && (!req1 || lg_q))
                    state_d = GNT0;
                else if (req1)
                    state_d = GNT1;
            end
            GNT0: begin
                if (!req0) begin
                    // Request withdrawn mid-stall: no completion, lg kept
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (done) begin
                    lg_d    = 1'b0;
                    state_d = req1 ? GNT1 : IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != TMO) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GNT1: begin
                if (!req1) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (done) begin
                    lg_d    = 1'b1;
                    state_d = req0 ? GNT0 : IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != TMO) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; reset leaves m0 winning the first tie
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            lg_q          <= 1'b1;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lg_q    <= lg_d;
            cnt_q   <= cnt_d;
            if (abort)
                timeout_err_q <= 1'b1;
        end
    end

    // Memory-side mux: granted master passes through, writes take priority
    always_comb begin
        bus.s_address   = 32'h0;
        bus.s_writedata = 32'h0;
        bus.s_byteenable = 4'h0;
        bus.s_read      = 1'b0;
        bus.s_write     = 1'b0;
        if (gnt0) begin
            bus.s_address    = bus.m0_address;
            bus.s_writedata  = bus.m0_writedata;
            bus.s_byteenable = bus.m0_byteenable;
            bus.s_write      = bus.m0_write & ~abort;
            bus.s_read       = bus.m0_read & ~bus.m0_write & ~abort;
        end else if (gnt1) begin
            bus.s_address    = bus.m1_address;
            bus.s_writedata  = bus.m1_writedata;
            bus.s_byteenable = bus.m1_byteenable;
            bus.s_write      = bus.m1_write & ~abort;
            bus.s_read       = bus.m1_read & ~bus.m1_write & ~abort;
        end
    end

    // Master-side responses: release only the granted master on completion
    assign bus.m0_waitrequest = ~(gnt0 & (~bus.s_waitrequest | abort));
    assign bus.m1_waitrequest = ~(gnt1 & (~bus.s_waitrequest | abort));
    assign bus.m0_readdata    = abort ? 32'h0 : bus.s_readdata;
    assign bus.m1_readdata    = abort ? 32'h0 : bus.s_readdata;
    assign bus.timeout_err    = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips_bus_arbiter
//  Purpose  : Self-checking bench for mips_bus_arbiter: a cycle table for
//             arbitration and data paths, plus hand sequences for the
//             watchdog, asynchronous reset and dropped-request cases.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mips_bus_arbiter;

    localparam logic [31:0] A0  = 32'hBFC00000;
    localparam logic [31:0] A1  = 32'hBFC00010;
    localparam logic [31:0] D0  = 32'h11111111;
    localparam logic [31:0] D1  = 32'h00000078;
    localparam logic [3:0]  BE0 = 4'hF;
    localparam logic [3:0]  BE1 = 4'b0001;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    mips_bus_arbiter_if bus ();

    mips_bus_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        r0, w0, r1, w1, swr;
        logic [31:0] srd;
        logic        ew0, ew1, esr, esw;
        logic [31:0] eaddr, ewd, erd;
        logic [3:0]  ebe;
    } vec_t;

    vec_t tbl [20];

    // g: 0 = nothing on the memory port, 1 = m0 routed, 2 = m1 routed
    function automatic vec_t mk(input logic rst, input logic r0, input logic w0,
                                input logic r1, input logic w1, input logic swr,
                                input logic [31:0] srd, input int g,
                                input logic ew0, input logic ew1,
                                input logic esr, input logic esw);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.w0 = w0; v.r1 = r1; v.w1 = w1;
        v.swr = swr; v.srd = srd;
        v.ew0 = ew0; v.ew1 = ew1; v.esr = esr; v.esw = esw;
        v.erd = srd;
        v.eaddr = (g == 1) ? A0  : (g == 2) ? A1  : 32'h0;
        v.ewd   = (g == 1) ? D0  : (g == 2) ? D1  : 32'h0;
        v.ebe   = (g == 1) ? BE0 : (g == 2) ? BE1 : 4'h0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic r1, input logic w1,
                         input logic swr, input logic [31:0] srd);
        bus.m0_read = r0; bus.m0_write = w0;
        bus.m1_read = r1; bus.m1_write = w1;
        bus.s_waitrequest = swr; bus.s_readdata = srd;
    endtask

    // One cycle: apply inputs after the falling edge, settle, then sample
    task automatic cyc(input logic r0, input logic w0, input logic r1, input logic w1,
                       input logic swr, input logic [31:0] srd);
        @(negedge clk);
        drive(r0, w0, r1, w1, swr, srd);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bus.m0_address = A0; bus.m0_writedata = D0; bus.m0_byteenable = BE0;
        bus.m1_address = A1; bus.m1_writedata = D1; bus.m1_byteenable = BE1;
        drive(0, 0, 0, 0, 1, 32'h0);

        //              rst r0 w0 r1 w1 swr srd            g  ew0 ew1 esr esw
        tbl[0]  = mk(1, 0, 0, 0, 0, 1, 32'h0,          0, 1, 1, 0, 0);
        tbl[1]  = mk(0, 1, 0, 0, 0, 1, 32'h0,          0, 1, 1, 0, 0);
        tbl[2]  = mk(0, 1, 0, 0, 0, 1, 32'h0,          1, 1, 1, 1, 0);
        tbl[3]  = mk(0, 1, 0, 0, 0, 1, 32'h0,          1, 1, 1, 1, 0);
        tbl[4]  = mk(0, 1, 0, 0, 0, 0, 32'h8C020004,   1, 0, 1, 1, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 1, 32'h0,          0, 1, 1, 0, 0);
        tbl[6]  = mk(1, 0, 0, 0, 0, 1, 32'h0,          0, 1, 1, 0, 0);
        tbl[7]  = mk(0, 1, 0, 1, 0, 1, 32'h0,          0, 1, 1, 0, 0);
        tbl[8]  = mk(0, 1, 0, 1, 0, 0, 32'hA5A50001,   1, 0, 1, 1, 0);
        tbl[9]  = mk(0, 0, 0, 1, 0, 0, 32'hA5A50002,   2, 1, 0, 1, 0);
        tbl[10] = mk(0, 1, 0, 1, 0, 1, 32'h0,          0, 1, 1, 0, 0);
        tbl[11] = mk(0, 1, 0, 1, 0, 0, 32'hA5A50003,   1, 0, 1, 1, 0);
        tbl[12] = mk(0, 1, 0, 1, 0, 0, 32'hA5A50004,   2, 1, 0, 1, 0);
        tbl[13] = mk(0, 1, 0, 0, 0, 0, 32'hA5A50005,   1, 0, 1, 1, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 1, 32'h0,          0, 1, 1, 0, 0);
        tbl[15] = mk(0, 1, 0, 1, 1, 1, 32'h0,          0, 1, 1, 0, 0);
        tbl[16] = mk(0, 1, 0, 1, 1, 1, 32'h0,          2, 1, 1, 0, 1);
        tbl[17] = mk(0, 1, 0, 1, 1, 0, 32'hA5A50006,   2, 1, 0, 0, 1);
        tbl[18] = mk(0, 1, 0, 0, 0, 0, 32'hA5A50007,   1, 0, 1, 1, 0);
        tbl[19] = mk(0, 0, 0, 0, 0, 1, 32'h0,          0, 1, 1, 0, 0);

        // Reset state before any clock activity matters
        #1;
        chk("rst_w0", bus.m0_waitrequest, 1'b1);
        chk("rst_w1", bus.m1_waitrequest, 1'b1);
        chk("rst_sread", bus.s_read, 1'b0);
        chk("rst_terr", bus.timeout_err, 1'b0);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            reset = tbl[i].rst;
            drive(tbl[i].r0, tbl[i].w0, tbl[i].r1, tbl[i].w1, tbl[i].swr, tbl[i].srd);
            #1;
            chk($sformatf("v%0d_w0", i),    bus.m0_waitrequest, tbl[i].ew0);
            chk($sformatf("v%0d_w1", i),    bus.m1_waitrequest, tbl[i].ew1);
            chk($sformatf("v%0d_sread", i), bus.s_read,         tbl[i].esr);
            chk($sformatf("v%0d_swrite", i), bus.s_write,       tbl[i].esw);
            chk($sformatf("v%0d_saddr", i), bus.s_address,      tbl[i].eaddr);
            chk($sformatf("v%0d_swdata", i), bus.s_writedata,   tbl[i].ewd);
            chk($sformatf("v%0d_sbe", i),   bus.s_byteenable,   tbl[i].ebe);
            chk($sformatf("v%0d_rd0", i),   bus.m0_readdata,    tbl[i].erd);
            chk($sformatf("v%0d_rd1", i),   bus.m1_readdata,    tbl[i].erd);
            chk($sformatf("v%0d_terr", i),  bus.timeout_err,    1'b0);
        end

        // Watchdog: memory never answers an m0 read
        do_reset();
        cyc(1, 0, 0, 0, 1, 32'hDEADBEEF);
        chk("to_idle_sread", bus.s_read, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            cyc(1, 0, 0, 0, 1, 32'hDEADBEEF);
            chk($sformatf("to_stall%0d_w0", k), bus.m0_waitrequest, 1'b1);
            chk($sformatf("to_stall%0d_sread", k), bus.s_read, 1'b1);
        end
        cyc(1, 0, 0, 0, 1, 32'hDEADBEEF);
        chk("to_abort_w0", bus.m0_waitrequest, 1'b0);
        chk("to_abort_rd0", bus.m0_readdata, 32'h0);
        chk("to_abort_sread", bus.s_read, 1'b0);
        chk("to_abort_w1", bus.m1_waitrequest, 1'b1);
        cyc(0, 0, 0, 0, 1, 32'h0);
        chk("to_after_terr", bus.timeout_err, 1'b1);
        chk("to_after_w0", bus.m0_waitrequest, 1'b1);
        cyc(0, 0, 0, 0, 1, 32'h0);
        cyc(0, 0, 0, 0, 1, 32'h0);
        chk("to_sticky_terr", bus.timeout_err, 1'b1);

        // Asynchronous reset during a stalled m1 write
        do_reset();
        chk("ar_terr_cleared", bus.timeout_err, 1'b0);
        cyc(0, 0, 1, 1, 1, 32'h0);
        cyc(0, 0, 1, 1, 1, 32'h0);
        chk("ar_pre_swrite", bus.s_write, 1'b1);
        chk("ar_pre_w1", bus.m1_waitrequest, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_swrite_drop", bus.s_write, 1'b0);
        chk("ar_w1_held", bus.m1_waitrequest, 1'b1);
        chk("ar_saddr_drop", bus.s_address, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(1, 0, 1, 0, 1, 32'h0);
        #1;
        chk("ar_idle_sread", bus.s_read, 1'b0);
        cyc(1, 0, 1, 0, 0, 32'h12345678);
        chk("ar_first_saddr", bus.s_address, A0);
        chk("ar_first_w0", bus.m0_waitrequest, 1'b0);
        chk("ar_first_w1", bus.m1_waitrequest, 1'b1);

        // m0 drops its read while stalled; lg must stay on m1
        do_reset();
        cyc(1, 0, 1, 0, 1, 32'h0);
        cyc(1, 0, 1, 0, 1, 32'h0);
        chk("dr_gnt_saddr", bus.s_address, A0);
        cyc(0, 0, 1, 0, 1, 32'h0);
        chk("dr_drop_sread", bus.s_read, 1'b0);
        chk("dr_drop_w0", bus.m0_waitrequest, 1'b1);
        chk("dr_drop_w1", bus.m1_waitrequest, 1'b1);
        cyc(1, 0, 1, 0, 1, 32'h0);
        chk("dr_idle_saddr", bus.s_address, 32'h0);
        chk("dr_idle_sread", bus.s_read, 1'b0);
        cyc(1, 0, 1, 0, 0, 32'hCAFEF00D);
        chk("dr_tie_saddr", bus.s_address, A0);
        chk("dr_tie_w0", bus.m0_waitrequest, 1'b0);
        chk("dr_tie_rd0", bus.m0_readdata, 32'hCAFEF00D);
        chk("dr_tie_w1", bus.m1_waitrequest, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
- Shares the single 32-bit Avalon-style memory port of mips_cpu_bus between two requesters: instruction fetch (m0) and data load/store (m1).
- A registered 3-state FSM grants one master at a time and holds the grant for a full transaction, completed by waitrequest low.
- Simultaneous requests are resolved round-robin.
- A per-transaction watchdog aborts transactions that stall too long.

Parameters:
- TIMEOUT_CYCLES, 64, stalled cycles allowed per grant before abort; 0 disables the watchdog.
- CNT_W, 8, width of the watchdog counter; TIMEOUT_CYCLES < 2^CNT_W.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- mN_address  in  32  master N byte address (N = 0, 1)
- mN_read  in  1  master N read request
- mN_write  in  1  master N write request
- mN_writedata  in  32  master N write data
- mN_byteenable  in  4  master N byte lanes
- mN_waitrequest  out  1  master N stall
- mN_readdata  out  32  read data to master N
- s_address  out  32  to memory
- s_read  out  1  to memory
- s_write  out  1  to memory
- s_writedata  out  32  to memory
- s_byteenable  out  4  to memory
- s_waitrequest  in  1  memory stall
- s_readdata  in  32  memory read data, valid in the cycle s_waitrequest = 0
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- Request definition: reqN = mN_read | mN_write. If both read and write are high, the access is a write; s_read is forced to 0.
- FSM states: IDLE, GNT0, GNT1. Reset enters IDLE, clears the counter, clears timeout_err, and sets the last-granted pointer lg = 1 so m0 wins the first tie.
- IDLE:
  - req0 only -> GNT0.
  - req1 only -> GNT1.
  - both -> grant the master != lg.
  - none -> stay in IDLE.
  - Arbitration latency is exactly one cycle; a grant is never given in the same cycle the request is first seen.
- GNTn, completion cycle (s_waitrequest = 0, or watchdog abort):
  - lg <= n.
  - Other master requesting -> GNT(other); otherwise -> IDLE.
  - Back-to-back accesses by the same master therefore always pass through one IDLE cycle.
- GNTn with reqn = 0 (protocol violation, request dropped while stalled): -> IDLE next cycle. No completion is signalled and lg is unchanged.
- Slave outputs are combinational from state and the granted master:
  - In GNTn, s_* = mn_* (with the write-priority rule above).
  - In IDLE, s_read = s_write = 0, s_address = 0, s_writedata = 0, s_byteenable = 0.
- Master waitrequest: mN_waitrequest = ~(state == GNTN & (~s_waitrequest | abort)). It is 1 in IDLE and while the other master is granted, including during reset.
- Master readdata: mN_readdata = s_readdata when not aborting, and 32'h0 in an abort cycle. Both masters see the same value; it is meaningful only in the cycle their waitrequest = 0.
- Watchdog:
  - cnt clears on every grant entry and on IDLE.
  - cnt increments each GNTn cycle with s_waitrequest = 1, saturating at TIMEOUT_CYCLES.
  - abort = (TIMEOUT_CYCLES != 0) & GNTn & s_waitrequest & (cnt == TIMEOUT_CYCLES).
  - In the abort cycle: s_read = s_write = 0, the master is released with readdata 0, and timeout_err <= 1, held until reset.
- Writes complete in the s_waitrequest = 0 cycle; the arbiter adds no buffering of data, address or byteenable.
- Asynchronous reset mid-transaction: the FSM returns to IDLE immediately, slave strobes drop to 0 without waiting for a clock edge, and the in-flight access is discarded.

Test Plan:
- Reset, then m0 read 0xBFC00000, memory stalls 2 cycles returning 0x8C020004 -> s_read high from cycle 1; m0_waitrequest low with m0_readdata = 0x8C020004 in cycle 3; FSM back in IDLE in cycle 4.
- Both masters request in the same cycle after reset -> m0 is granted first; m1 is granted in the cycle after m0 completes with no IDLE gap. Repeat with both requesting again -> m0 first again (lg = 1), and each master alternately loses ties.
- m1 write, address 0xBFC00010, byteenable 4'b0001, writedata 0x00000078, with read also high -> s_write = 1, s_read = 0, s_byteenable = 4'b0001; m0 meanwhile sees waitrequest = 1 throughout.
- TIMEOUT_CYCLES = 4, memory holds s_waitrequest = 1 forever on an m0 read -> abort in the 5th granted cycle: m0_waitrequest = 0, m0_readdata = 0, s_read = 0, timeout_err = 1 and remains 1.
- Reset asserted during a stalled m1 write -> s_write = 0 and m1_waitrequest = 1 asynchronously; after release the first grant follows normal IDLE arbitration.
- m0 drops its read while stalled -> FSM returns to IDLE next cycle; the next tie with m1 still grants m0 (lg unchanged).
